// File: rtl/vga_mem_sched.sv
// Port-A scheduler for the VGA frame buffer: core load/store always wins, and a
// linear fill engine writes a constant pattern into otherwise idle cycles.
module vga_mem_sched #(
  parameter int unsigned WORDS = 9600,
  parameter int unsigned AW    = 14
) (
  input  logic          QClk,
  input  logic          RstN,
  input  logic [AW-1:0] CoreAddr,
  input  logic [31:0]   CoreData,
  input  logic [3:0]    CoreByteEn,
  input  logic          CoreWrEn,
  input  logic          CoreRdEn,
  output logic [31:0]   CoreRspData,
  output logic          CoreRspValid,
  input  logic          FillStart,
  input  logic [AW-1:0] FillBase,
  input  logic [AW:0]   FillCount,
  input  logic [31:0]   FillData,
  output logic          FillBusy,
  output logic          FillDone,
  output logic          FillErr,
  output logic [AW-1:0] MemAddr,
  output logic [31:0]   MemData,
  output logic [3:0]    MemByteEn,
  output logic          MemWrEn,
  output logic          MemRdEn,
  input  logic [31:0]   MemQ
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  localparam logic [AW+1:0] WordsExt = WORDS[AW+1:0];
  localparam logic [AW-1:0] PtrOne   = 1;
  localparam logic [AW:0]   RemOne   = 1;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   remain_q;
  logic [31:0]   pat_q;
  logic          err_q;
  logic          rsp_valid_q;

  logic [AW+1:0] base_ext;
  logic [AW+1:0] span_end;
  logic          range_bad;
  logic          core_req;
  logic          fill_wr;

  // One extra bit over AW+1 so base+count cannot overflow the compare.
  assign base_ext  = {2'b00, FillBase};
  assign span_end  = base_ext + {1'b0, FillCount};
  assign range_bad = (base_ext >= WordsExt) || (span_end > WordsExt);

  assign core_req = CoreWrEn | CoreRdEn;
  assign fill_wr  = (state_q == StFill) && !core_req;

  always_ff @(posedge QClk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remain_q    <= '0;
      pat_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      err_q       <= 1'b0;
      rsp_valid_q <= CoreRdEn;
      case (state_q)
        StIdle: begin
          if (FillStart) begin
            if (range_bad) begin
              err_q <= 1'b1;
            end else if (FillCount == '0) begin
              state_q <= StDone;
            end else begin
              ptr_q    <= FillBase;
              remain_q <= FillCount;
              pat_q    <= FillData;
              state_q  <= StFill;
            end
          end
        end
        StFill: begin
          if (fill_wr) begin
            ptr_q    <= ptr_q + PtrOne;
            remain_q <= remain_q - RemOne;
            if (remain_q == RemOne) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign FillBusy     = (state_q == StFill);
  assign FillDone     = (state_q == StDone);
  assign FillErr      = err_q;
  assign CoreRspValid = rsp_valid_q;
  assign CoreRspData  = MemQ;

  always_comb begin
    MemAddr   = '0;
    MemData   = '0;
    MemByteEn = '0;
    MemWrEn   = 1'b0;
    MemRdEn   = 1'b0;
    if (core_req) begin
      MemAddr   = CoreAddr;
      MemData   = CoreData;
      MemByteEn = CoreByteEn;
      MemWrEn   = CoreWrEn;
      MemRdEn   = CoreRdEn;
    end else if (fill_wr) begin
      MemAddr   = ptr_q;
      MemData   = pat_q;
      MemByteEn = 4'hF;
      MemWrEn   = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_mem_sched.sv
// Bench for vga_mem_sched: a memory model plus write/read scoreboards checked on
// every negative clock edge, and one task per scenario.
module tb_vga_mem_sched;

  localparam int AW = 14;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } wr_t;

  logic          QClk = 1'b0;
  logic          RstN = 1'b0;
  logic [AW-1:0] CoreAddr = '0;
  logic [31:0]   CoreData = '0;
  logic [3:0]    CoreByteEn = '0;
  logic          CoreWrEn = 1'b0;
  logic          CoreRdEn = 1'b0;
  logic [31:0]   CoreRspData;
  logic          CoreRspValid;
  logic          FillStart = 1'b0;
  logic [AW-1:0] FillBase = '0;
  logic [AW:0]   FillCount = '0;
  logic [31:0]   FillData = '0;
  logic          FillBusy;
  logic          FillDone;
  logic          FillErr;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemData;
  logic [3:0]    MemByteEn;
  logic          MemWrEn;
  logic          MemRdEn;
  logic [31:0]   MemQ = '0;

  int checks = 0;
  int errors = 0;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem [0:9599];

  vga_mem_sched dut (
    .QClk(QClk), .RstN(RstN),
    .CoreAddr(CoreAddr), .CoreData(CoreData), .CoreByteEn(CoreByteEn),
    .CoreWrEn(CoreWrEn), .CoreRdEn(CoreRdEn),
    .CoreRspData(CoreRspData), .CoreRspValid(CoreRspValid),
    .FillStart(FillStart), .FillBase(FillBase), .FillCount(FillCount), .FillData(FillData),
    .FillBusy(FillBusy), .FillDone(FillDone), .FillErr(FillErr),
    .MemAddr(MemAddr), .MemData(MemData), .MemByteEn(MemByteEn),
    .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .MemQ(MemQ)
  );

  always #5 QClk = ~QClk;

  // Memory model with one-cycle read latency.
  always @(posedge QClk) begin
    if (MemWrEn === 1'b1 && MemAddr < 14'd9600) begin
      for (int b = 0; b < 4; b++)
        if (MemByteEn[b]) mem[MemAddr][8*b +: 8] <= MemData[8*b +: 8];
    end
    if (MemRdEn === 1'b1 && MemAddr < 14'd9600) MemQ <= mem[MemAddr];
  end

  always @(negedge QClk) begin : monitor
    wr_t         e;
    logic [31:0] r;
    if (MemWrEn === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr=%0d data=%h be=%h, required no write",
                 MemAddr, MemData, MemByteEn);
      end else begin
        e = exp_wr.pop_front();
        if ({MemAddr, MemData, MemByteEn} !== e) begin
          errors++;
          $display("FAIL wr_seq got addr=%0d data=%h be=%h, required addr=%0d data=%h be=%h",
                   MemAddr, MemData, MemByteEn, e.addr, e.data, e.be);
        end
      end
    end
    if (CoreRspValid === 1'b1) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got valid data=%h, required no response", CoreRspData);
      end else begin
        r = exp_rd.pop_front();
        if (CoreRspData !== r) begin
          errors++;
          $display("FAIL rd_data got %h, required %h", CoreRspData, r);
        end
      end
    end
  end

  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    exp_wr.push_back(e);
  endtask

  // Returns in cycle T+1 of an accepted command.
  task automatic start_fill(input logic [AW-1:0] base, input logic [AW:0] cnt,
                            input logic [31:0] pat);
    FillStart = 1'b1;
    FillBase  = base;
    FillCount = cnt;
    FillData  = pat;
    tick();
    FillStart = 1'b0;
  endtask

  task automatic wait_done(input int start_cyc, output int cyc, output bit err_seen);
    cyc      = start_cyc;
    err_seen = 1'b0;
    while (FillDone !== 1'b1 && cyc < 12000) begin
      if (FillErr === 1'b1) err_seen = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL %s_drained got wr=%0d rd=%0d pending, required 0", name,
               exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({FillBusy, FillDone, FillErr, CoreRspValid, MemWrEn, MemRdEn} !== 6'b0 ||
        MemAddr !== '0 || MemData !== '0 || MemByteEn !== '0) begin
      errors++;
      $display("FAIL reset_outputs got flags=%b addr=%0d data=%h be=%h, required all 0",
               {FillBusy, FillDone, FillErr, CoreRspValid, MemWrEn, MemRdEn},
               MemAddr, MemData, MemByteEn);
    end
    tick();
    tick();
    RstN = 1'b1;
    tick();
    checks++;
    if (FillBusy !== 1'b0 || FillDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b, required 0 0", FillBusy, FillDone);
    end
  endtask

  task automatic test_clear_screen();
    int cyc;
    bit err;
    for (int i = 0; i < 9600; i++) push_wr(AW'(i), 32'h0, 4'hF);
    start_fill(14'd0, 15'd9600, 32'h0);
    checks++;
    if (FillBusy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy got %b, required 1", FillBusy);
    end
    wait_done(1, cyc, err);
    checks++;
    if (cyc != 9601 || FillBusy !== 1'b0 || err) begin
      errors++;
      $display("FAIL clear_done got cycle=%0d busy=%b err=%b, required cycle=9601 busy=0 err=0",
               cyc, FillBusy, err);
    end
    tick();
    checks++;
    if (FillDone !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_pulse got %b, required 0", FillDone);
    end
    check_drained("clear");
  endtask

  task automatic test_contention();
    int cyc;
    bit err;
    push_wr(14'd100, 32'hFFFF_FFFF, 4'hF);
    push_wr(14'd2000, 32'h1234_5678, 4'b0101);
    push_wr(14'd2001, 32'h9ABC_DEF0, 4'b1000);
    for (int i = 101; i < 108; i++) push_wr(AW'(i), 32'hFFFF_FFFF, 4'hF);
    start_fill(14'd100, 15'd8, 32'hFFFF_FFFF);
    tick();
    CoreWrEn = 1'b1; CoreAddr = 14'd2000; CoreData = 32'h1234_5678; CoreByteEn = 4'b0101;
    tick();
    CoreAddr = 14'd2001; CoreData = 32'h9ABC_DEF0; CoreByteEn = 4'b1000;
    tick();
    CoreWrEn = 1'b0; CoreAddr = '0; CoreData = '0; CoreByteEn = '0;
    wait_done(4, cyc, err);
    checks++;
    if (cyc != 11 || err) begin
      errors++;
      $display("FAIL contention_done got cycle=%0d err=%b, required cycle=11 err=0", cyc, err);
    end
    tick();
    check_drained("contention");
  endtask

  task automatic test_core_read();
    int cyc;
    bit err;
    push_wr(14'd5, 32'hA5A5_0F0F, 4'hF);
    CoreWrEn = 1'b1; CoreAddr = 14'd5; CoreData = 32'hA5A5_0F0F; CoreByteEn = 4'hF;
    tick();
    CoreWrEn = 1'b0; CoreData = '0; CoreByteEn = '0;
    tick();
    push_wr(14'd200, 32'h1111_1111, 4'hF);
    for (int i = 201; i < 204; i++) push_wr(AW'(i), 32'h1111_1111, 4'hF);
    start_fill(14'd200, 15'd4, 32'h1111_1111);
    tick();
    CoreRdEn = 1'b1; CoreAddr = 14'd5;
    exp_rd.push_back(32'hA5A5_0F0F);
    #1;
    checks++;
    if (MemRdEn !== 1'b1 || MemWrEn !== 1'b0 || MemAddr !== 14'd5) begin
      errors++;
      $display("FAIL read_mux got rd=%b wr=%b addr=%0d, required rd=1 wr=0 addr=5",
               MemRdEn, MemWrEn, MemAddr);
    end
    tick();
    CoreRdEn = 1'b0; CoreAddr = '0;
    checks++;
    if (CoreRspValid !== 1'b1 || CoreRspData !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL read_rsp got valid=%b data=%h, required valid=1 data=a5a50f0f",
               CoreRspValid, CoreRspData);
    end
    wait_done(3, cyc, err);
    checks++;
    if (cyc != 6 || err) begin
      errors++;
      $display("FAIL read_done got cycle=%0d err=%b, required cycle=6 err=0", cyc, err);
    end
    tick();
    check_drained("read");
  endtask

  task automatic test_range();
    int cyc;
    bit err;
    start_fill(14'd9599, 15'd2, 32'h5555_5555);
    checks++;
    if (FillErr !== 1'b1 || FillBusy !== 1'b0 || FillDone !== 1'b0) begin
      errors++;
      $display("FAIL range_over got err=%b busy=%b done=%b, required 1 0 0",
               FillErr, FillBusy, FillDone);
    end
    tick();
    checks++;
    if (FillErr !== 1'b0 || FillBusy !== 1'b0) begin
      errors++;
      $display("FAIL range_pulse got err=%b busy=%b, required 0 0", FillErr, FillBusy);
    end
    start_fill(14'd9600, 15'd0, 32'h0);
    checks++;
    if (FillErr !== 1'b1 || FillDone !== 1'b0) begin
      errors++;
      $display("FAIL range_base got err=%b done=%b, required 1 0", FillErr, FillDone);
    end
    tick();
    push_wr(14'd9599, 32'hDEAD_BEEF, 4'hF);
    start_fill(14'd9599, 15'd1, 32'hDEAD_BEEF);
    wait_done(1, cyc, err);
    checks++;
    if (cyc != 2 || err) begin
      errors++;
      $display("FAIL range_last got cycle=%0d err=%b, required cycle=2 err=0", cyc, err);
    end
    tick();
    start_fill(14'd10, 15'd0, 32'h0);
    checks++;
    if (FillDone !== 1'b1 || FillErr !== 1'b0 || FillBusy !== 1'b0) begin
      errors++;
      $display("FAIL range_zero got done=%b err=%b busy=%b, required 1 0 0",
               FillDone, FillErr, FillBusy);
    end
    tick();
    checks++;
    if (FillDone !== 1'b0) begin
      errors++;
      $display("FAIL range_zero_pulse got %b, required 0", FillDone);
    end
    check_drained("range");
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    bit err;
    for (int i = 300; i < 310; i++) push_wr(AW'(i), 32'h0000_CAFE, 4'hF);
    start_fill(14'd300, 15'd50, 32'h0000_CAFE);
    for (int i = 0; i < 9; i++) tick();
    @(negedge QClk);
    #2;
    RstN = 1'b0;
    #1;
    checks++;
    if ({FillBusy, FillDone, FillErr, CoreRspValid, MemWrEn, MemRdEn} !== 6'b0 ||
        MemAddr !== '0 || MemData !== '0 || MemByteEn !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got flags=%b addr=%0d data=%h, required all 0",
               {FillBusy, FillDone, FillErr, CoreRspValid, MemWrEn, MemRdEn}, MemAddr, MemData);
    end
    tick();
    tick();
    RstN = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 400; i < 403; i++) push_wr(AW'(i), 32'h0BAD_F00D, 4'hF);
    start_fill(14'd400, 15'd3, 32'h0BAD_F00D);
    wait_done(1, cyc, err);
    checks++;
    if (cyc != 4 || err) begin
      errors++;
      $display("FAIL midreset_restart got cycle=%0d err=%b, required cycle=4 err=0", cyc, err);
    end
    tick();
    check_drained("midreset");
  endtask

  task automatic test_start_while_busy();
    int cyc;
    bit err;
    for (int i = 500; i < 505; i++) push_wr(AW'(i), 32'h7777_7777, 4'hF);
    start_fill(14'd500, 15'd5, 32'h7777_7777);
    FillStart = 1'b1; FillBase = 14'd9599; FillCount = 15'd2; FillData = 32'h0;
    tick();
    FillStart = 1'b0;
    wait_done(2, cyc, err);
    checks++;
    if (cyc != 6 || err) begin
      errors++;
      $display("FAIL busy_ignore got cycle=%0d err=%b, required cycle=6 err=0", cyc, err);
    end
    FillStart = 1'b1; FillBase = 14'd9599; FillCount = 15'd2;
    tick();
    FillStart = 1'b0;
    checks++;
    if (FillErr !== 1'b0 || FillBusy !== 1'b0 || FillDone !== 1'b0) begin
      errors++;
      $display("FAIL done_ignore got err=%b busy=%b done=%b, required 0 0 0",
               FillErr, FillBusy, FillDone);
    end
    tick();
    check_drained("busy");
  endtask

  initial begin
    test_reset();
    test_clear_screen();
    test_contention();
    test_core_read();
    test_range();
    test_reset_mid_fill();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
